// File: rtl/sdf_pair_buffer.sv
// Radix-2 SDF stage buffer: pairs x[n] with x[n+HALF_LEN] for an external
// butterfly adder, streams the sums straight out and parks the differences in
// the delay memory until the next frame's FILL inputs push them out.
module sdf_pair_buffer #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned HALF_LEN  = 4,
  parameter int unsigned ADDR_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [bit_width-1:0] Re_in,
  input  logic signed [bit_width-1:0] Im_in,
  output logic                        bf_en,
  output logic signed [bit_width-1:0] Re_a,
  output logic signed [bit_width-1:0] Im_a,
  output logic signed [bit_width-1:0] Re_b,
  output logic signed [bit_width-1:0] Im_b,
  input  logic signed [bit_width-1:0] Re_sum,
  input  logic signed [bit_width-1:0] Im_sum,
  input  logic signed [bit_width-1:0] Re_diff,
  input  logic signed [bit_width-1:0] Im_diff,
  output logic                        out_valid,
  output logic signed [bit_width-1:0] Re_out,
  output logic signed [bit_width-1:0] Im_out
);

  // StFillDrain doubles as the sticky "pending" flag: once a PAIR phase has
  // finished, every later FILL phase has differences to drain.
  typedef enum logic [1:0] {StFillFirst, StFillDrain, StPair} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   idx;
  logic                phase;
  logic                is_pair;
  logic                is_drain;

  logic                s1_valid_q;
  logic                s1_pair_q;
  logic [ADDR_W-1:0]   s1_idx_q;

  logic signed [bit_width-1:0] mem_re [HALF_LEN];
  logic signed [bit_width-1:0] mem_im [HALF_LEN];

  assign idx   = cnt_q[ADDR_W-1:0];
  assign phase = cnt_q[ADDR_W];

  // Next-state: phase changes when the input counter wraps out of its last index.
  always_comb begin
    state_d  = state_q;
    is_pair  = 1'b0;
    is_drain = 1'b0;
    case (state_q)
      StPair:      is_pair  = 1'b1;
      StFillDrain: is_drain = 1'b1;
      default:     ;
    endcase
    if (in_valid && (idx == '1)) begin
      state_d = phase ? StFillDrain : StPair;
    end
  end

  // Control state and input sample counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFillFirst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_valid) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: read the delay line (before this edge's write) and present operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pair_q  <= 1'b0;
      s1_idx_q   <= '0;
      bf_en      <= 1'b0;
      Re_a       <= '0;
      Im_a       <= '0;
      Re_b       <= '0;
      Im_b       <= '0;
    end else if (in_valid) begin
      Re_a     <= mem_re[idx];
      Im_a     <= mem_im[idx];
      s1_idx_q <= idx;
      if (is_pair) begin
        Re_b       <= Re_in;
        Im_b       <= Im_in;
        s1_valid_q <= 1'b1;
        s1_pair_q  <= 1'b1;
        bf_en      <= 1'b1;
      end else begin
        s1_valid_q <= is_drain;
        s1_pair_q  <= 1'b0;
        bf_en      <= 1'b0;
      end
    end else begin
      s1_valid_q <= 1'b0;
      bf_en      <= 1'b0;
    end
  end

  // Stage 2: emit the adder sum for pairs, or the drained difference held in Re_a/Im_a.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Re_out    <= '0;
      Im_out    <= '0;
    end else begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        if (s1_pair_q) begin
          Re_out <= Re_sum;
          Im_out <= Im_sum;
        end else begin
          Re_out <= Re_a;
          Im_out <= Im_a;
        end
      end
    end
  end

  // Delay memory: FILL write (stage 1) and difference write-back (stage 2) never
  // share an address on the same edge, so both ports land together.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && !is_pair) begin
        mem_re[idx] <= Re_in;
        mem_im[idx] <= Im_in;
      end
      if (s1_valid_q && s1_pair_q) begin
        mem_re[s1_idx_q] <= Re_diff;
        mem_im[s1_idx_q] <= Im_diff;
      end
    end
  end

endmodule

// File: tb/tb_sdf_pair_buffer.sv
// Directed bench for sdf_pair_buffer with HALF_LEN=4 and a behavioural adder.
module tb_sdf_pair_buffer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] Re_in, Im_in;
  logic               bf_en;
  logic signed [15:0] Re_a, Im_a, Re_b, Im_b;
  logic signed [15:0] Re_sum, Im_sum, Re_diff, Im_diff;
  logic               out_valid;
  logic signed [15:0] Re_out, Im_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Butterfly adder model
  assign Re_sum  = Re_a + Re_b;
  assign Im_sum  = Im_a + Im_b;
  assign Re_diff = Re_a - Re_b;
  assign Im_diff = Im_a - Im_b;

  sdf_pair_buffer #(
    .bit_width(16),
    .HALF_LEN (4),
    .ADDR_W   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .Re_in    (Re_in),
    .Im_in    (Im_in),
    .bf_en    (bf_en),
    .Re_a     (Re_a),
    .Im_a     (Im_a),
    .Re_b     (Re_b),
    .Im_b     (Im_b),
    .Re_sum   (Re_sum),
    .Im_sum   (Im_sum),
    .Re_diff  (Re_diff),
    .Im_diff  (Im_diff),
    .out_valid(out_valid),
    .Re_out   (Re_out),
    .Im_out   (Im_out)
  );

  // Drive one cycle of input, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic signed [15:0] re, input logic signed [15:0] im);
    in_valid = v;
    Re_in    = re;
    Im_in    = im;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(1'b0, 16'sd0, 16'sd0);
    step(1'b0, 16'sd0, 16'sd0);
    rst_n = 1'b1;
  endtask

  // Input schedule: contiguous (k = j) or one idle cycle between inputs (k = j/2).
  task automatic sched(input bit gapped, input int j, output bit v, output int k);
    if (gapped) begin
      v = (j < 16) && (j % 2 == 0);
      k = j / 2;
    end else begin
      v = (j < 8);
      k = j;
    end
  endtask

  // One frame of samples 1..8 on Re (or Im); sums 6,8,10,12 appear 2 cycles after
  // each PAIR input, outputs hold between valid cycles.
  task automatic test_frame(input string name, input bit gapped, input bit im_path,
                            input bit do_reset);
    int                 nsteps, k, pk;
    bit                 v, pv, exp_ov, exp_bf;
    logic signed [15:0] last, act, other, smp;
    if (do_reset) apply_reset();
    nsteps = gapped ? 18 : 10;
    last   = 16'sd0;
    for (int j = 0; j < nsteps; j++) begin
      sched(gapped, j, v, k);
      smp = 16'(k + 1);
      step(v, im_path ? 16'sd0 : smp, im_path ? smp : 16'sd0);
      exp_bf = v && (k >= 4);
      pv = 1'b0;
      pk = 0;
      if (j > 0) sched(gapped, j - 1, pv, pk);
      exp_ov = pv && (pk >= 4);
      if (exp_ov) last = 16'(2 * pk - 2);
      act   = im_path ? Im_out : Re_out;
      other = im_path ? Re_out : Im_out;
      n_vec++;
      if (bf_en !== exp_bf) begin
        n_err++;
        $display("FAIL %s bf_en step %0d: got %b want %b", name, j, bf_en, exp_bf);
      end
      n_vec++;
      if (out_valid !== exp_ov) begin
        n_err++;
        $display("FAIL %s out_valid step %0d: got %b want %b", name, j, out_valid, exp_ov);
      end
      n_vec++;
      if (act !== last) begin
        n_err++;
        $display("FAIL %s data step %0d: got %0d want %0d", name, j, act, last);
      end
      n_vec++;
      if (other !== 16'sd0) begin
        n_err++;
        $display("FAIL %s other_channel step %0d: got %0d want 0", name, j, other);
      end
    end
  endtask

  // Reset with in_valid high clears every output register; runs after a frame so
  // the registers hold nonzero values beforehand.
  task automatic test_reset();
    logic signed [15:0] got [8];
    string              nm  [8];
    rst_n = 1'b0;
    step(1'b1, 16'sd55, 16'sd66);
    step(1'b1, 16'sd55, 16'sd66);
    got = '{16'(out_valid), 16'(bf_en), Re_out, Im_out, Re_a, Im_a, Re_b, Im_b};
    nm  = '{"out_valid", "bf_en", "Re_out", "Im_out", "Re_a", "Im_a", "Re_b", "Im_b"};
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (got[i] !== 16'sd0) begin
        n_err++;
        $display("FAIL reset %s: got %0d want 0", nm[i], got[i]);
      end
    end
    rst_n = 1'b1;
    step(1'b0, 16'sd0, 16'sd0);
  endtask

  // Two contiguous frames 1..16: sums, then drained -4s, then 22..28, no gaps.
  task automatic test_back_to_back();
    int                 i;
    bit                 v, exp_ov, exp_bf;
    logic signed [15:0] last;
    apply_reset();
    last = 16'sd0;
    for (int j = 0; j < 18; j++) begin
      v = (j < 16);
      step(v, 16'(j + 1), 16'sd0);
      exp_bf = v && ((j % 8) >= 4);
      i      = j - 1;
      exp_ov = (j >= 1) && (i < 16) && (i >= 4);
      if (exp_ov) last = (i >= 8 && i < 12) ? -16'sd4 : 16'(2 * i - 2);
      n_vec++;
      if (bf_en !== exp_bf) begin
        n_err++;
        $display("FAIL b2b bf_en step %0d: got %b want %b", j, bf_en, exp_bf);
      end
      n_vec++;
      if (out_valid !== exp_ov) begin
        n_err++;
        $display("FAIL b2b out_valid step %0d: got %b want %b", j, out_valid, exp_ov);
      end
      n_vec++;
      if (Re_out !== last) begin
        n_err++;
        $display("FAIL b2b Re_out step %0d: got %0d want %0d", j, Re_out, last);
      end
      n_vec++;
      if (Im_out !== 16'sd0) begin
        n_err++;
        $display("FAIL b2b Im_out step %0d: got %0d want 0", j, Im_out);
      end
    end
  endtask

  // Reset after input 6 of a frame: in-flight pair and partial frame are dropped,
  // the next frame behaves like a first frame (no drained differences).
  task automatic test_mid_reset();
    apply_reset();
    for (int j = 0; j < 6; j++) step(1'b1, 16'(j + 1), 16'sd0);
    n_vec++;
    if (out_valid !== 1'b1 || Re_out !== 16'sd6) begin
      n_err++;
      $display("FAIL midrst pre_reset_out: got v=%b %0d want v=1 6", out_valid, Re_out);
    end
    rst_n = 1'b0;
    step(1'b1, 16'sd99, 16'sd99);
    rst_n = 1'b1;
    n_vec++;
    if (out_valid !== 1'b0 || bf_en !== 1'b0 || Re_out !== 16'sd0) begin
      n_err++;
      $display("FAIL midrst in_reset: got v=%b bf=%b %0d want 0 0 0", out_valid, bf_en, Re_out);
    end
    test_frame("midrst_refill", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    Re_in    = '0;
    Im_in    = '0;
    apply_reset();
    test_frame("first_frame", 1'b0, 1'b0, 1'b0);
    test_reset();
    test_back_to_back();
    test_frame("gapped", 1'b1, 1'b0, 1'b1);
    test_frame("im_path", 1'b0, 1'b1, 1'b1);
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
